axi_latency_monitor: RTL and testbench

//   Consumes the per-beat transaction strobes (tt_arvalid/tt_rlast/tt_awvalid/tt_bvalid + IDs) produced

---
 rtl/axi_latency_monitor.sv | 198 +++++++++++++++++++
 tb/tb_axi_latency_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_latency_monitor.sv
// axi_latency_monitor
//   Turns the AR/R-last and AW/B transaction strobes seen around the host-memory
//   AXI master into per-direction latency statistics. Each issued ID is
//   timestamped from a free-running counter. The matching completion then
//   produces latency = (now - stamp) mod 2**TS_WIDTH. That latency feeds the
//   count/sum/min/max statistics and the sticky protocol-error flags.
//
//   Strobe semantics: every tt_* strobe marks one completed handshake in the
//   cycle it is high. The monitor never back-pressures, so there is no ready.
//
//   Parameters: ID_WIDTH (ID width, 2**ID_WIDTH table entries per direction),
//               TS_WIDTH (timestamp width), CNT_WIDTH (counter/sum width,
//               must be >= TS_WIDTH).
//   Ports:      clk, rst (sync, active-high), clear, enable,
//               tt_arvalid/tt_arid, tt_rlast/tt_rid, tt_awvalid/tt_awid,
//               tt_bvalid/tt_bid,
//               rd_/wr_ count, lat_sum, lat_min, lat_max, pending,
//               err_flags {wr_orphan, wr_dup, rd_orphan, rd_dup}, lat_hist.
//   Optional:   ACTION_LAT_HIST_EN adds 8 x 16-bit latency bins per direction.
//               When it is not defined, lat_hist is 0.

module axi_latency_monitor_dir #(
  parameter int ID_WIDTH  = 5,
  parameter int TS_WIDTH  = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TS_WIDTH-1:0]  ts,
  input  logic                 issue,
  input  logic [ID_WIDTH-1:0]  issue_id,
  input  logic                 done,
  input  logic [ID_WIDTH-1:0]  done_id,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] lat_sum,
  output logic [TS_WIDTH-1:0]  lat_min,
  output logic [TS_WIDTH-1:0]  lat_max,
  output logic [ID_WIDTH:0]    pending,
  output logic                 err_dup,
  output logic                 err_orphan,
  output logic [63:0]          hist
);
  localparam int N = 1 << ID_WIDTH;

  logic [N-1:0]          pend;
  logic [TS_WIDTH-1:0]   stamp [N];
  logic                  s1_valid;
  logic [TS_WIDTH-1:0]   s1_lat;
  logic [CNT_WIDTH:0]    sum_ext;

  // A completion is valid only against the pending bit as it was before this
  // cycle. A same-ID re-issue in the completion cycle is a legal reuse, not a duplicate.
  logic done_ok, same_id, is_dup, issue_new;
  assign done_ok   = done && pend[done_id];
  assign same_id   = done_ok && (done_id == issue_id);
  assign is_dup    = issue && pend[issue_id] && !same_id;
  assign issue_new = issue && !is_dup;

  assign sum_ext = {1'b0, lat_sum} + {{(CNT_WIDTH + 1 - TS_WIDTH){1'b0}}, s1_lat};

  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= '0;
      pending <= '0;
      for (int i = 0; i < N; i++) stamp[i] <= '0;
    end else begin
      if (done_ok) pend[done_id] <= 1'b0;
      // Issue is applied after the clear, so a same-ID issue+completion keeps pend set.
      if (issue) begin
        pend[issue_id]  <= 1'b1;
        stamp[issue_id] <= ts;
      end
      pending <= pending + {{ID_WIDTH{1'b0}}, issue_new} - {{ID_WIDTH{1'b0}}, done_ok};
    end
  end

  // Stage 1: capture latency using the stamp from before this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lat   <= '0;
    end else begin
      s1_valid <= done_ok && enable && !clear;
      s1_lat   <= ts - stamp[done_id];
    end
  end

  // Stage 2: statistics and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count      <= '0;
      lat_sum    <= '0;
      lat_min    <= '1;
      lat_max    <= '0;
      err_dup    <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (s1_valid) begin
        if (count != '1) count <= count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        lat_sum <= sum_ext[CNT_WIDTH] ? '1 : sum_ext[CNT_WIDTH-1:0];
        if (s1_lat < lat_min) lat_min <= s1_lat;
        if (s1_lat > lat_max) lat_max <= s1_lat;
      end
      if (is_dup) err_dup <= 1'b1;
      if (done && !done_ok) err_orphan <= 1'b1;
    end
  end

`ifdef ACTION_LAT_HIST_EN
  logic [15:0] bins [8];
  logic [2:0]  bin_sel;
  logic [31:0] lat32;

  assign lat32 = 32'(s1_lat);

  // Bin i (i < 7) collects latencies below 16 << i. Bin 7 takes everything else.
  always_comb begin
    bin_sel = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (lat32 < (32'd16 << i)) bin_sel = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < 8; i++) bins[i] <= '0;
    end else if (s1_valid && bins[bin_sel] != 16'hFFFF) begin
      bins[bin_sel] <= bins[bin_sel] + 16'd1;
    end
  end

  always_comb begin
    hist = '0;
    for (int i = 0; i < 8; i++) hist[16*i +: 16] = bins[i];
  end
`else
  assign hist = '0;
`endif
endmodule

module axi_latency_monitor #(
  parameter int ID_WIDTH  = 5,
  parameter int TS_WIDTH  = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 tt_arvalid,
  input  logic [ID_WIDTH-1:0]  tt_arid,
  input  logic                 tt_rlast,
  input  logic [ID_WIDTH-1:0]  tt_rid,
  input  logic                 tt_awvalid,
  input  logic [ID_WIDTH-1:0]  tt_awid,
  input  logic                 tt_bvalid,
  input  logic [ID_WIDTH-1:0]  tt_bid,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] rd_lat_sum,
  output logic [TS_WIDTH-1:0]  rd_lat_min,
  output logic [TS_WIDTH-1:0]  rd_lat_max,
  output logic [ID_WIDTH:0]    rd_pending,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] wr_lat_sum,
  output logic [TS_WIDTH-1:0]  wr_lat_min,
  output logic [TS_WIDTH-1:0]  wr_lat_max,
  output logic [ID_WIDTH:0]    wr_pending,
  output logic [3:0]           err_flags,
  output logic [127:0]         lat_hist
);
  logic [TS_WIDTH-1:0] ts;
  logic rd_dup, rd_orphan, wr_dup, wr_orphan;
  logic [63:0] rd_hist, wr_hist;

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + {{(TS_WIDTH-1){1'b0}}, 1'b1};
  end

  axi_latency_monitor_dir #(.ID_WIDTH(ID_WIDTH), .TS_WIDTH(TS_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_rd (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .ts(ts),
    .issue(tt_arvalid), .issue_id(tt_arid), .done(tt_rlast), .done_id(tt_rid),
    .count(rd_count), .lat_sum(rd_lat_sum), .lat_min(rd_lat_min), .lat_max(rd_lat_max),
    .pending(rd_pending), .err_dup(rd_dup), .err_orphan(rd_orphan), .hist(rd_hist)
  );

  axi_latency_monitor_dir #(.ID_WIDTH(ID_WIDTH), .TS_WIDTH(TS_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_wr (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .ts(ts),
    .issue(tt_awvalid), .issue_id(tt_awid), .done(tt_bvalid), .done_id(tt_bid),
    .count(wr_count), .lat_sum(wr_lat_sum), .lat_min(wr_lat_min), .lat_max(wr_lat_max),
    .pending(wr_pending), .err_dup(wr_dup), .err_orphan(wr_orphan), .hist(wr_hist)
  );

  assign err_flags = {wr_orphan, wr_dup, rd_orphan, rd_dup};
  assign lat_hist  = {wr_hist, rd_hist};
endmodule

// File: tb/tb_axi_latency_monitor.sv
// tb_axi_latency_monitor
//   Directed and random checks of axi_latency_monitor. The DUT is built with a
//   narrow timestamp and counters, so that wrap and saturation are quick to reach.
//   The reference model keeps issue times per ID and applies the latency rules
//   directly in per-cycle transaction order.
module tb_axi_latency_monitor;
  localparam int IW = 5;
  localparam int TW = 10;
  localparam int CW = 10;
  localparam int TSM = 1 << TW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, clear = 1'b0, enable = 1'b0;
  logic arv = 1'b0, rl = 1'b0, awv = 1'b0, bv = 1'b0;
  logic [IW-1:0] arid = '0, rid = '0, awid = '0, bid = '0;
  logic [CW-1:0] rd_count, rd_lat_sum, wr_count, wr_lat_sum;
  logic [TW-1:0] rd_lat_min, rd_lat_max, wr_lat_min, wr_lat_max;
  logic [IW:0]   rd_pending, wr_pending;
  logic [3:0]    err_flags;
  logic [127:0]  lat_hist;

  axi_latency_monitor #(.ID_WIDTH(IW), .TS_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable),
    .tt_arvalid(arv), .tt_arid(arid), .tt_rlast(rl), .tt_rid(rid),
    .tt_awvalid(awv), .tt_awid(awid), .tt_bvalid(bv), .tt_bid(bid),
    .rd_count(rd_count), .rd_lat_sum(rd_lat_sum), .rd_lat_min(rd_lat_min),
    .rd_lat_max(rd_lat_max), .rd_pending(rd_pending),
    .wr_count(wr_count), .wr_lat_sum(wr_lat_sum), .wr_lat_min(wr_lat_min),
    .wr_lat_max(wr_lat_max), .wr_pending(wr_pending),
    .err_flags(err_flags), .lat_hist(lat_hist)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model. Index d: 0 = read, 1 = write.
  int now;
  bit pend_m [2][32];
  int stamp_m [2][32];
  int cnt_m [2], sum_m [2], mn_m [2], mx_m [2];
  int hist_m [2][8];
  bit dup_m [2], orph_m [2];
  int tests = 0, failed = 0;

  function automatic void model_reset_stats();
    for (int d = 0; d < 2; d++) begin
      cnt_m[d] = 0; sum_m[d] = 0; mn_m[d] = TSM - 1; mx_m[d] = 0;
      dup_m[d] = 0; orph_m[d] = 0;
      for (int b = 0; b < 8; b++) hist_m[d][b] = 0;
    end
  endfunction

  function automatic void model_reset();
    model_reset_stats();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) begin pend_m[d][i] = 0; stamp_m[d][i] = 0; end
    now = 0;
  endfunction

  function automatic int bin_of(int lat);
    int b = 0, lim = 16;
    if (lat >= 1024) return 7;
    while (lat >= lim) begin b++; lim = lim * 2; end
    return b;
  endfunction

  // Completion first (against the prior table), then issue.
  function automatic void model_dir(int d, bit iv, int iid, bit cv, int cid, bit en);
    int lat, b;
    if (cv) begin
      if (pend_m[d][cid]) begin
        lat = ((now % TSM) - stamp_m[d][cid] + TSM) % TSM;
        pend_m[d][cid] = 0;
        if (en) begin
          cnt_m[d] = (cnt_m[d] + 1 > CMAX) ? CMAX : cnt_m[d] + 1;
          sum_m[d] = (sum_m[d] + lat > CMAX) ? CMAX : sum_m[d] + lat;
          if (lat < mn_m[d]) mn_m[d] = lat;
          if (lat > mx_m[d]) mx_m[d] = lat;
          b = bin_of(lat);
          if (hist_m[d][b] < 65535) hist_m[d][b]++;
        end
      end else orph_m[d] = 1;
    end
    if (iv) begin
      if (pend_m[d][iid]) dup_m[d] = 1;
      pend_m[d][iid] = 1;
      stamp_m[d][iid] = now % TSM;
    end
  endfunction

  function automatic int pend_count(int d);
    int c = 0;
    for (int i = 0; i < 32; i++) c += pend_m[d][i];
    return c;
  endfunction

  function automatic logic [127:0] hist_exp();
    logic [127:0] v = '0;
`ifdef ACTION_LAT_HIST_EN
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 8; b++) v[d*64 + b*16 +: 16] = 16'(hist_m[d][b]);
`endif
    return v;
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: model consumes the driven cycle, then the clock edge, then idle inputs.
  task automatic cycle();
    if (!rst) begin
      model_dir(0, arv, int'(arid), rl, int'(rid), enable);
      model_dir(1, awv, int'(awid), bv, int'(bid), enable);
      if (clear) model_reset_stats();
    end
    @(posedge clk);
    if (rst) model_reset(); else now++;
    #1;
    arv = 0; rl = 0; awv = 0; bv = 0; clear = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_ts(input int t);
    while ((now % TSM) != t) cycle();
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_rd_count"}, 128'(rd_count), 128'(cnt_m[0]));
    chk({tag, "_rd_sum"},   128'(rd_lat_sum), 128'(sum_m[0]));
    chk({tag, "_rd_min"},   128'(rd_lat_min), 128'(mn_m[0]));
    chk({tag, "_rd_max"},   128'(rd_lat_max), 128'(mx_m[0]));
    chk({tag, "_rd_pend"},  128'(rd_pending), 128'(pend_count(0)));
    chk({tag, "_wr_count"}, 128'(wr_count), 128'(cnt_m[1]));
    chk({tag, "_wr_sum"},   128'(wr_lat_sum), 128'(sum_m[1]));
    chk({tag, "_wr_min"},   128'(wr_lat_min), 128'(mn_m[1]));
    chk({tag, "_wr_max"},   128'(wr_lat_max), 128'(mx_m[1]));
    chk({tag, "_wr_pend"},  128'(wr_pending), 128'(pend_count(1)));
    chk({tag, "_err"},      128'(err_flags), 128'({orph_m[1], dup_m[1], orph_m[0], dup_m[0]}));
    chk({tag, "_hist"},     lat_hist, hist_exp());
  endtask

  initial begin
    model_reset();
    rst = 1; idle(3); rst = 0;
    check_all("reset");
    chk("reset_min_ones", 128'(rd_lat_min), 128'(10'h3FF));

    // Test 1: AR id3 at ts10, R last at ts52, then check the two-cycle pipeline.
    enable = 1;
    wait_ts(10); arv = 1; arid = 3; cycle();
    wait_ts(52); rl = 1; rid = 3; cycle();
    chk("t1_pipe_stage1", 128'(rd_count), 128'(0));
    cycle();
    chk("t1_count", 128'(rd_count), 128'(1));
    chk("t1_sum", 128'(rd_lat_sum), 128'(42));
    chk("t1_min", 128'(rd_lat_min), 128'(42));
    chk("t1_max", 128'(rd_lat_max), 128'(42));
    check_all("t1");
    clear = 1; cycle();
    check_all("clear1");

    // Test 2: three overlapping reads with latencies 5, 7 and 9.
    arv = 1; arid = 0; cycle();
    arv = 1; arid = 1; cycle();
    arv = 1; arid = 2; cycle();
    idle(2); rl = 1; rid = 0; cycle();
    idle(3); rl = 1; rid = 2; cycle();
    rl = 1; rid = 1; cycle();
    idle(2);
    chk("t2_count", 128'(rd_count), 128'(3));
    chk("t2_sum", 128'(rd_lat_sum), 128'(21));
    chk("t2_min", 128'(rd_lat_min), 128'(5));
    chk("t2_max", 128'(rd_lat_max), 128'(9));
    chk("t2_pend", 128'(rd_pending), 128'(0));
    check_all("t2");

    // Test 3: orphan B response, then clear.
    bv = 1; bid = 7; cycle(); idle(2);
    chk("t3_err", 128'(err_flags), 128'(4'b1000));
    chk("t3_wr_count", 128'(wr_count), 128'(0));
    clear = 1; cycle();
    chk("t3_err_clr", 128'(err_flags), 128'(0));

    // Test 4: timestamp wrap.
    wait_ts(10'h3F0); arv = 1; arid = 2; cycle();
    wait_ts(10'h010); rl = 1; rid = 2; cycle(); idle(2);
    chk("t4_sum", 128'(rd_lat_sum), 128'(32));
    chk("t4_max", 128'(rd_lat_max), 128'(32));
`ifdef ACTION_LAT_HIST_EN
    chk("t4_bin2", 128'(lat_hist[47:32]), 128'(1));
`endif
    check_all("t4");

    // Test 5: same-cycle completion and re-issue of id4.
    arv = 1; arid = 4; cycle();
    idle(19); rl = 1; rid = 4; arv = 1; arid = 4; cycle(); idle(2);
    chk("t5_min", 128'(rd_lat_min), 128'(20));
    chk("t5_pend", 128'(rd_pending), 128'(1));
    chk("t5_no_dup", 128'(err_flags), 128'(0));
    idle(5); rl = 1; rid = 4; cycle(); idle(2);
    check_all("t5");

    // Test 6: disabled stats still track the table; then sum saturation.
    clear = 1; cycle();
    enable = 0;
    awv = 1; awid = 1; cycle(); idle(3);
    bv = 1; bid = 1; cycle(); idle(2);
    chk("t6_wr_pend", 128'(wr_pending), 128'(0));
    chk("t6_wr_count", 128'(wr_count), 128'(0));
    chk("t6_wr_min", 128'(wr_lat_min), 128'(10'h3FF));
    enable = 1;
    for (int i = 0; i < 3; i++) begin arv = 1; arid = IW'(i); cycle(); end
    idle(400);
    for (int i = 0; i < 3; i++) begin rl = 1; rid = IW'(i); cycle(); end
    idle(2);
    chk("t6_sum_sat", 128'(rd_lat_sum), 128'(CMAX));
    chk("t6_count", 128'(rd_count), 128'(3));
    check_all("t6");

    // A completion followed immediately by clear is dropped.
    clear = 1; cycle();
    arv = 1; arid = 6; cycle(); idle(3);
    rl = 1; rid = 6; cycle();
    clear = 1; cycle(); idle(2);
    chk("clr_drop_count", 128'(rd_count), 128'(0));
    check_all("clr_drop");

    // Reset mid-operation discards the table.
    arv = 1; arid = 5; cycle();
    rst = 1; cycle(); rst = 0;
    idle(2); rl = 1; rid = 5; cycle(); idle(1);
    chk("rst_orphan", 128'(err_flags), 128'(4'b0010));
    chk("rst_pend", 128'(rd_pending), 128'(0));

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      arv = ($urandom_range(0, 2) == 0); arid = IW'($urandom_range(0, 7));
      rl  = ($urandom_range(0, 2) == 0); rid  = IW'($urandom_range(0, 7));
      awv = ($urandom_range(0, 2) == 0); awid = IW'($urandom_range(0, 7));
      bv  = ($urandom_range(0, 2) == 0); bid  = IW'($urandom_range(0, 7));
      enable = ($urandom_range(0, 3) != 0);
      clear  = ($urandom_range(0, 60) == 0);
      cycle();
      chk("rand_rd_pend", 128'(rd_pending), 128'(pend_count(0)));
      chk("rand_wr_pend", 128'(wr_pending), 128'(pend_count(1)));
    end
    idle(2);
    check_all("rand");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
